dvp_camera_tx: RTL and testbench



---
 rtl/dvp_camera_tx_pkg.sv | 23 ++
 rtl/dvp_camera_tx_timing.sv | 102 ++++++++++
 rtl/dvp_camera_tx.sv | 102 ++++++++++
 tb/tb_dvp_camera_tx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dvp_camera_tx_pkg.sv
// Shared types and counter-width helpers for the DVP camera transmitter.
package dvp_camera_tx_pkg;

  typedef enum logic [2:0] {IDLE, VSYNC, V_BACK, ACTIVE, V_FRONT} state_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int col_w(input int aw, input int hb);
    return cnt_w(aw + hb);
  endfunction

  function automatic int line_w(input int vs, input int vb, input int ah, input int vf);
    int m;
    m = vs;
    if (vb > m) m = vb;
    if (ah > m) m = ah;
    if (vf > m) m = vf;
    return cnt_w(m);
  endfunction

endpackage

// File: rtl/dvp_camera_tx_timing.sv
// Frame/line state engine; flags describe the slot of the next clock so the top can register them.
module dvp_camera_tx_timing
  import dvp_camera_tx_pkg::*;
#(
  parameter int ACTIVE_WIDTH  = 640,
  parameter int ACTIVE_HEIGHT = 480,
  parameter int H_BLANK       = 144,
  parameter int VSYNC_LINES   = 3,
  parameter int V_BACK_LINES  = 12,
  parameter int V_FRONT_LINES = 10,
  parameter int COL_W  = col_w(ACTIVE_WIDTH, H_BLANK),
  parameter int LINE_W = line_w(VSYNC_LINES, V_BACK_LINES, ACTIVE_HEIGHT, V_FRONT_LINES)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  output logic              active_next_o,
  output logic              vsync_next_o,
  output logic              frame_end_next_o,
  output logic              frame_start_o,
  output logic [COL_W-1:0]  col_next_o,
  output logic [LINE_W-1:0] line_next_o
);

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(ACTIVE_WIDTH + H_BLANK - 1);
  localparam logic [LINE_W-1:0] VS_LAST  = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] VB_LAST  = LINE_W'((V_BACK_LINES > 0) ? V_BACK_LINES - 1 : 0);
  localparam logic [LINE_W-1:0] AC_LAST  = LINE_W'(ACTIVE_HEIGHT - 1);
  localparam logic [LINE_W-1:0] VF_LAST  = LINE_W'((V_FRONT_LINES > 0) ? V_FRONT_LINES - 1 : 0);

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                start_d;

  function automatic logic [LINE_W-1:0] last_line(input state_t s);
    case (s)
      VSYNC:   return VS_LAST;
      V_BACK:  return VB_LAST;
      ACTIVE:  return AC_LAST;
      default: return VF_LAST;
    endcase
  endfunction

  // Last clock of a frame: end of V_FRONT, or end of ACTIVE when there is no front porch.
  function automatic logic is_end(input state_t s, input logic [COL_W-1:0] c,
                                  input logic [LINE_W-1:0] l);
    return ((s == V_FRONT) || (s == ACTIVE && V_FRONT_LINES == 0)) &&
           (c == LAST_COL) && (l == last_line(s));
  endfunction

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    start_d = 1'b0;
    if (state_q == IDLE) begin
      col_d  = '0;
      line_d = '0;
      if (enable_i) begin
        state_d = VSYNC;
        start_d = 1'b1;
      end
    end else if (col_q != LAST_COL) begin
      col_d = col_q + 1'b1;
    end else begin
      col_d = '0;
      if (line_q != last_line(state_q)) begin
        line_d = line_q + 1'b1;
      end else begin
        line_d = '0;
        case (state_q)
          VSYNC:   state_d = (V_BACK_LINES > 0) ? V_BACK : ACTIVE;
          V_BACK:  state_d = ACTIVE;
          ACTIVE:  state_d = (V_FRONT_LINES > 0) ? V_FRONT : (enable_i ? VSYNC : IDLE);
          default: state_d = enable_i ? VSYNC : IDLE;
        endcase
        start_d = (state_d == VSYNC);
      end
    end
  end

  assign active_next_o    = (state_d == ACTIVE) && (col_d < COL_W'(ACTIVE_WIDTH));
  assign vsync_next_o     = (state_d == VSYNC);
  assign frame_end_next_o = is_end(state_d, col_d, line_d);
  assign frame_start_o    = start_d;
  assign col_next_o       = col_d;
  assign line_next_o      = line_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/dvp_camera_tx.sv
// DVP camera sensor model: valid/ready pixel source to registered hsync/vsync/data.
// Optional internal test pattern enabled by `define DVP_CAMERA_TX_TEST_PATTERN_EN.
module dvp_camera_tx
  import dvp_camera_tx_pkg::*;
#(
  parameter int         ACTIVE_WIDTH    = 640,
  parameter int         ACTIVE_HEIGHT   = 480,
  parameter int         H_BLANK         = 144,
  parameter int         VSYNC_LINES     = 3,
  parameter int         V_BACK_LINES    = 12,
  parameter int         V_FRONT_LINES   = 10,
  parameter logic [7:0] UNDERFLOW_PIXEL = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        pattern_en_i,
  input  logic [7:0]  pixel_i,
  input  logic        pixel_valid_i,
  output logic        pixel_ready_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [7:0]  d_o,
  output logic        frame_done_o,
  output logic [15:0] frame_count_o,
  output logic        underflow_o
);

  localparam int COL_W  = col_w(ACTIVE_WIDTH, H_BLANK);
  localparam int LINE_W = line_w(VSYNC_LINES, V_BACK_LINES, ACTIVE_HEIGHT, V_FRONT_LINES);

  logic              active_nx, vsync_nx, fend_nx, fstart;
  logic [COL_W-1:0]  col_nx;
  logic [LINE_W-1:0] line_nx;
  logic              pat_use;
  logic [7:0]        pat_pix, d_d;
  logic              hsync_q, vsync_q, done_q, uf_q;
  logic [7:0]        d_q;
  logic [15:0]       cnt_q;

  dvp_camera_tx_timing #(
    .ACTIVE_WIDTH (ACTIVE_WIDTH),  .ACTIVE_HEIGHT(ACTIVE_HEIGHT),
    .H_BLANK      (H_BLANK),       .VSYNC_LINES  (VSYNC_LINES),
    .V_BACK_LINES (V_BACK_LINES),  .V_FRONT_LINES(V_FRONT_LINES),
    .COL_W        (COL_W),         .LINE_W       (LINE_W)
  ) u_timing (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i),
    .active_next_o(active_nx), .vsync_next_o(vsync_nx),
    .frame_end_next_o(fend_nx), .frame_start_o(fstart),
    .col_next_o(col_nx), .line_next_o(line_nx)
  );

`ifdef DVP_CAMERA_TX_TEST_PATTERN_EN
  logic pat_q;
  // Mode is latched on entry to VSYNC and held for the whole frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    pat_q <= 1'b0;
    else if (fstart) pat_q <= pattern_en_i;
  end
  assign pat_use = pat_q;
  assign pat_pix = 8'(32'(col_nx) + 32'(line_nx));
`else
  logic unused_pat;
  assign unused_pat = ^{pattern_en_i, fstart, col_nx, line_nx};
  assign pat_use    = 1'b0;
  assign pat_pix    = UNDERFLOW_PIXEL;
`endif

  assign pixel_ready_o = active_nx & ~pat_use;

  always_comb begin
    d_d = '0;
    if (active_nx)
      d_d = pat_use ? pat_pix : (pixel_valid_i ? pixel_i : UNDERFLOW_PIXEL);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      d_q     <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      hsync_q <= active_nx;
      vsync_q <= vsync_nx;
      d_q     <= d_d;
      done_q  <= fend_nx;
      if (fend_nx) cnt_q <= cnt_q + 16'd1;
      if (pixel_ready_o && !pixel_valid_i) uf_q <= 1'b1;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign d_o           = d_q;
  assign frame_done_o  = done_q;
  assign frame_count_o = cnt_q;
  assign underflow_o   = uf_q;

endmodule

// File: tb/tb_dvp_camera_tx.sv
// Self-checking bench for dvp_camera_tx against a frame-position reference model.
module tb_dvp_camera_tx;

  localparam int AW = 4, AH = 2, HB = 2, VS = 1, VB = 1, VF = 1;
  localparam int L  = AW + HB;
  localparam int FL = L * (VS + VB + AH + VF);

  logic        clk_i = 1'b0, rst_n_i = 1'b0, enable_i = 1'b0, pattern_en_i = 1'b0;
  logic        pixel_valid_i = 1'b0;
  logic [7:0]  pixel_i = 8'h00;
  logic        pixel_ready_o, hsync_o, vsync_o, frame_done_o, underflow_o;
  logic [7:0]  d_o;
  logic [15:0] frame_count_o;

  always #5 clk_i = ~clk_i;

  dvp_camera_tx #(
    .ACTIVE_WIDTH(AW), .ACTIVE_HEIGHT(AH), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK_LINES(VB), .V_FRONT_LINES(VF), .UNDERFLOW_PIXEL(8'h00)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i), .pattern_en_i(pattern_en_i),
    .pixel_i(pixel_i), .pixel_valid_i(pixel_valid_i), .pixel_ready_o(pixel_ready_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .d_o(d_o), .frame_done_o(frame_done_o),
    .frame_count_o(frame_count_o), .underflow_o(underflow_o)
  );

  int tests = 0, fails = 0;

  // Model: m_pos is the 1-based clock index within the current frame (1..FL).
  bit          m_run, m_pat, m_fd, m_uf;
  int          m_pos, src;
  logic [7:0]  m_d;
  logic [15:0] m_cnt;

  function automatic bit slot_act(input int p);
    int ln, c;
    ln = (p - 1) / L;
    c  = (p - 1) % L;
    return (p >= 1) && (ln >= VS + VB) && (ln < VS + VB + AH) && (c < AW);
  endfunction

  function automatic bit slot_vs(input int p);
    return (p >= 1) && ((p - 1) / L < VS);
  endfunction

  function automatic bit exp_ready();
    return m_run && (m_pos < FL) && slot_act(m_pos + 1) && !m_pat;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pat = 0; m_fd = 0; m_uf = 0; m_pos = 0; m_d = 8'h00; m_cnt = 16'd0;
  endtask

  task automatic check_all();
    chk("hsync", 32'(hsync_o), 32'(m_run && slot_act(m_pos)));
    chk("vsync", 32'(vsync_o), 32'(m_run && slot_vs(m_pos)));
    chk("data", 32'(d_o), 32'(m_d));
    chk("frame_done", 32'(frame_done_o), 32'(m_fd));
    chk("frame_count", 32'(frame_count_o), 32'(m_cnt));
    chk("underflow", 32'(underflow_o), 32'(m_uf));
    chk("ready", 32'(pixel_ready_o), 32'(exp_ready()));
  endtask

  // Check the current clock, then advance the model across the next rising edge.
  task automatic tick();
    bit rdy, nrun, npat;
    int npos;
    check_all();
    rdy  = exp_ready();
    npat = m_pat;
    if (!m_run || m_pos == FL) begin
      nrun = enable_i;
      npos = enable_i ? 1 : 0;
      if (enable_i) npat = pattern_en_i;
    end else begin
      nrun = 1;
      npos = m_pos + 1;
    end
`ifndef DVP_CAMERA_TX_TEST_PATTERN_EN
    npat = 0;
`endif
    if (nrun && slot_act(npos)) begin
      if (npat)               m_d = 8'(((npos - 1) / L - (VS + VB)) + ((npos - 1) % L));
      else if (pixel_valid_i) m_d = pixel_i;
      else begin
        m_d  = 8'h00;
        m_uf = 1;
      end
    end else m_d = 8'h00;
    m_fd = nrun && (npos == FL);
    if (m_fd) m_cnt++;
    if (rdy && pixel_valid_i) src++;
    m_run = nrun; m_pos = npos; m_pat = npat;
    @(negedge clk_i);
  endtask

  initial begin
    bit found;
    model_reset();
    #3;
    check_all();
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Three back-to-back frames; third pixel of line 0 withheld in frame 2; enable drops mid frame 3.
    enable_i = 1'b1;
    src = 1;
    repeat (3 * FL + 8) begin
      pixel_valid_i = 1'b1;
      pixel_i = 8'(src);
      if (m_cnt == 1 && m_run && m_pos < FL && (m_pos / L) == VS + VB && (m_pos % L) == 2)
        pixel_valid_i = 1'b0;
      if (m_cnt == 2 && m_run && m_pos == 15) enable_i = 1'b0;
      tick();
    end
    chk("frames3", 32'(frame_count_o), 32'd3);
    chk("uf_sticky", 32'(underflow_o), 32'd1);

    // Randomized traffic: enable, valid, data and pattern select all vary.
    repeat (400) begin
      enable_i      = ($urandom % 4) != 0;
      pixel_valid_i = ($urandom % 5) != 0;
      pixel_i       = 8'($urandom);
      pattern_en_i  = ($urandom % 2) == 1;
      tick();
    end
    pattern_en_i = 1'b0;

    // Async reset landing on the 2nd active pixel of the first active line.
    enable_i = 1'b1;
    pixel_valid_i = 1'b1;
    found = 0;
    for (int i = 0; i < 4 * FL && !found; i++) begin
      if (m_run && slot_act(m_pos) && (m_pos - 1) % L == 1 && (m_pos - 1) / L == VS + VB)
        found = 1;
      else begin
        pixel_i = 8'($urandom);
        tick();
      end
    end
    chk("reach_2nd_pixel", 32'(found), 32'd1);
    chk("pre_rst_hsync", 32'(hsync_o), 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk_i);
    check_all();
    rst_n_i = 1'b1;
    enable_i = 1'b0;
    repeat (3) tick();
    enable_i = 1'b1;
    repeat (FL + 1) begin
      pixel_i = 8'($urandom);
      tick();
    end
    chk("count_after_rst", 32'(frame_count_o), 32'd1);

`ifdef DVP_CAMERA_TX_TEST_PATTERN_EN
    pattern_en_i = 1'b1;
    repeat (2 * FL) tick();
    pattern_en_i = 1'b0;
`endif

    enable_i = 1'b0;
    repeat (FL + 4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
